// File: rtl/generic_dpsram_be.sv
// Dual-port byte-enable SRAM with power-up clear sweep and write-first forwarding.
// Define GENERIC_DPSRAM_BE_OUTREG_EN to add a second output register stage (read latency 2).
module generic_dpsram_be #(
    parameter int DW = 32,
    parameter int DD = 1024,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          n_cs0,
    input  logic          n_cs1,
    input  logic          n_we0,
    input  logic          n_we1,
    input  logic [DW/8-1:0] n_be0,
    input  logic [DW/8-1:0] n_be1,
    input  logic [AW-1:0] ad0,
    input  logic [AW-1:0] ad1,
    input  logic [DW-1:0] di0,
    input  logic [DW-1:0] di1,
    output logic [DW-1:0] do0,
    output logic [DW-1:0] do1,
    output logic          dv0,
    output logic          dv1,
    output logic          init_busy
);

    localparam int BW = DW / 8;
    localparam logic [AW-1:0] LAST_AD = AW'(DD - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;

    logic [DW-1:0] mem [DD];

    logic          ad0_ok, ad1_ok;
    logic          rd0, rd1, wr0, wr1;
    logic [DW-1:0] rdata0, rdata1;
    logic [DW-1:0] do0_r, do1_r;
    logic          dv0_r, dv1_r;

    // ------------------------------------------------------------------
    // Controller: clear sweep, then normal operation until the next reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
            else                clr_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (clr_cnt == LAST_AD) state_nxt = READY;
            READY: state_nxt = READY;
        endcase
    end

    assign init_busy = (state == CLEAR);

    // ------------------------------------------------------------------
    // Access decode; out-of-range addresses never touch the array
    // ------------------------------------------------------------------
    assign ad0_ok = (32'(ad0) < DD);
    assign ad1_ok = (32'(ad1) < DD);

    assign rd0 = (state == READY) && !n_cs0 &&  n_we0;
    assign rd1 = (state == READY) && !n_cs1 &&  n_we1;
    assign wr0 = (state == READY) && !n_cs0 && !n_we0 && ad0_ok;
    assign wr1 = (state == READY) && !n_cs1 && !n_we1 && ad1_ok;

    // Read data merges the other port's same-cycle write (write-first)
    always_comb begin
        rdata0 = ad0_ok ? mem[ad0] : '0;
        rdata1 = ad1_ok ? mem[ad1] : '0;
        for (int i = 0; i < BW; i++) begin
            if (wr1 && (ad1 == ad0) && !n_be1[i]) rdata0[8*i +: 8] = di1[8*i +: 8];
            if (wr0 && (ad0 == ad1) && !n_be0[i]) rdata1[8*i +: 8] = di0[8*i +: 8];
        end
    end

    // NOTE: the array has no reset; its contents are defined only by the clear sweep.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            // Port 0 is assigned last so it wins on bytes both ports enable.
            for (int i = 0; i < BW; i++) begin
                if (wr1 && !n_be1[i]) mem[ad1][8*i +: 8] <= di1[8*i +: 8];
                if (wr0 && !n_be0[i]) mem[ad0][8*i +: 8] <= di0[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // First output stage: data holds unless a read is accepted
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            do0_r <= '0;
            do1_r <= '0;
            dv0_r <= 1'b0;
            dv1_r <= 1'b0;
        end else begin
            if (rd0) do0_r <= rdata0;
            if (rd1) do1_r <= rdata1;
            dv0_r <= rd0;
            dv1_r <= rd1;
        end
    end

`ifdef GENERIC_DPSRAM_BE_OUTREG_EN
    logic [DW-1:0] do0_q, do1_q;
    logic          dv0_q, dv1_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            do0_q <= '0;
            do1_q <= '0;
            dv0_q <= 1'b0;
            dv1_q <= 1'b0;
        end else begin
            do0_q <= do0_r;
            do1_q <= do1_r;
            dv0_q <= dv0_r;
            dv1_q <= dv1_r;
        end
    end

    assign do0 = do0_q;
    assign do1 = do1_q;
    assign dv0 = dv0_q;
    assign dv1 = dv1_q;
`else
    assign do0 = do0_r;
    assign do1 = do1_r;
    assign dv0 = dv0_r;
    assign dv1 = dv1_r;
`endif

endmodule

// File: tb/tb_generic_dpsram_be.sv
// Self-checking bench for generic_dpsram_be: directed vector table, corner sequences
// and randomized traffic against a word-level memory model.
module tb_generic_dpsram_be;

    localparam int DW = 32;
    localparam int DD = 16;
    localparam int AW = 4;
    localparam int BW = 4;
`ifdef GENERIC_DPSRAM_BE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_reset = 1'b1;
    logic          n_cs0, n_cs1, n_we0, n_we1;
    logic [BW-1:0] n_be0, n_be1;
    logic [AW-1:0] ad0, ad1;
    logic [DW-1:0] di0, di1;
    logic [DW-1:0] do0, do1, s_do0, s_do1;
    logic          dv0, dv1, init_busy, s_dv0, s_dv1, s_init_busy;

    generic_dpsram_be #(.DW(DW), .DD(DD), .AW(AW)) dut (
        .clk(clk), .n_reset(n_reset),
        .n_cs0(n_cs0), .n_cs1(n_cs1), .n_we0(n_we0), .n_we1(n_we1),
        .n_be0(n_be0), .n_be1(n_be1), .ad0(ad0), .ad1(ad1),
        .di0(di0), .di1(di1), .do0(do0), .do1(do1),
        .dv0(dv0), .dv1(dv1), .init_busy(init_busy)
    );

    // Shallower instance so that addresses >= depth are reachable
    generic_dpsram_be #(.DW(DW), .DD(12), .AW(AW)) dut_s (
        .clk(clk), .n_reset(n_reset),
        .n_cs0(n_cs0), .n_cs1(n_cs1), .n_we0(n_we0), .n_we1(n_we1),
        .n_be0(n_be0), .n_be1(n_be1), .ad0(ad0), .ad1(ad1),
        .di0(di0), .di1(di1), .do0(s_do0), .do1(s_do1),
        .dv0(s_dv0), .dv1(s_dv1), .init_busy(s_init_busy)
    );

    typedef struct {
        logic          n_cs;
        logic          n_we;
        logic [BW-1:0] n_be;
        logic [AW-1:0] ad;
        logic [DW-1:0] di;
    } op_t;

    typedef struct {
        op_t           p0;
        op_t           p1;
        logic [DW-1:0] do0;
        logic          dv0;
        logic          chk0;
        logic [DW-1:0] do1;
        logic          dv1;
        logic          chk1;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model: word array plus expected outputs one and two cycles back
    logic [DW-1:0] mem_m [DD];
    logic [DW-1:0] e1_do0, e1_do1, e2_do0, e2_do1;
    logic          e1_dv0, e1_dv1, e2_dv0, e2_dv1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t op_idle();
        op_t o;
        o.n_cs = 1'b1; o.n_we = 1'b1; o.n_be = '1; o.ad = '0; o.di = '0;
        return o;
    endfunction

    function automatic op_t op_rd(input logic [AW-1:0] a);
        op_t o;
        o = op_idle();
        o.n_cs = 1'b0; o.ad = a;
        return o;
    endfunction

    function automatic op_t op_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        op_t o;
        o.n_cs = 1'b0; o.n_we = 1'b0; o.n_be = be; o.ad = a; o.di = d;
        return o;
    endfunction

    function automatic vec_t mk(input op_t a, input op_t b,
                                input logic [DW-1:0] d0, input logic v0, input logic c0,
                                input logic [DW-1:0] d1, input logic v1, input logic c1);
        vec_t v;
        v.p0 = a; v.p1 = b;
        v.do0 = d0; v.dv0 = v0; v.chk0 = c0;
        v.do1 = d1; v.dv1 = v1; v.chk1 = c1;
        return v;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [BW-1:0] nbe);
        logic [DW-1:0] r;
        r = old;
        for (int i = 0; i < BW; i++)
            if (!nbe[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic apply(input op_t a, input op_t b);
        n_cs0 = a.n_cs; n_we0 = a.n_we; n_be0 = a.n_be; ad0 = a.ad; di0 = a.di;
        n_cs1 = b.n_cs; n_we1 = b.n_we; n_be1 = b.n_be; ad1 = b.ad; di1 = b.di;
    endtask

    task automatic model_reset();
        e1_do0 = '0; e1_do1 = '0; e2_do0 = '0; e2_do1 = '0;
        e1_dv0 = 1'b0; e1_dv1 = 1'b0; e2_dv0 = 1'b0; e2_dv1 = 1'b0;
    endtask

    task automatic model_cleared();
        for (int i = 0; i < DD; i++) mem_m[i] = '0;
    endtask

    // One cycle in READY: model the memory transaction, clock it, compare all outputs
    task automatic drive_cycle(input op_t a, input op_t b);
        logic [DW-1:0] nm [DD];
        apply(a, b);
        nm = mem_m;
        if (!b.n_cs && !b.n_we) nm[b.ad] = merge(nm[b.ad], b.di, b.n_be);
        if (!a.n_cs && !a.n_we) nm[a.ad] = merge(nm[a.ad], a.di, a.n_be);
        e2_do0 = e1_do0; e2_dv0 = e1_dv0;
        e2_do1 = e1_do1; e2_dv1 = e1_dv1;
        e1_dv0 = !a.n_cs && a.n_we;
        e1_dv1 = !b.n_cs && b.n_we;
        if (e1_dv0) e1_do0 = nm[a.ad];
        if (e1_dv1) e1_do1 = nm[b.ad];
        mem_m = nm;
        @(posedge clk); #1;
        check("model_do0", do0, (LAT == 1) ? e1_do0 : e2_do0);
        check("model_dv0", 32'(dv0), 32'((LAT == 1) ? e1_dv0 : e2_dv0));
        check("model_do1", do1, (LAT == 1) ? e1_do1 : e2_do1);
        check("model_dv1", 32'(dv1), 32'((LAT == 1) ? e1_dv1 : e2_dv1));
    endtask

    task automatic settle();
        for (int i = 1; i < LAT; i++) drive_cycle(op_idle(), op_idle());
    endtask

    // Release already done; disturb both ports and time the sweep
    task automatic run_sweep();
        int cnt = 0;
        int pulses = 0;
        apply(op_rd(4'd5), op_wr(4'd0, 32'hFFFF_FFFF, 4'b0000));
        do begin
            @(posedge clk); #1;
            cnt++;
            if (dv0 || dv1) pulses++;
        end while (init_busy && cnt < 100);
        check("sweep_len", 32'(cnt), 32'd16);
        check("sweep_no_dv", 32'(pulses), 32'd0);
        apply(op_idle(), op_idle());
        model_cleared();
    endtask

    task automatic read_all();
        for (int a = 0; a < DD; a++) drive_cycle(op_rd(AW'(a)), op_rd(AW'(DD - 1 - a)));
        settle();
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = mk(op_wr(4'd3, 32'hAABB_CCDD, 4'b0000), op_idle(),
                     32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vecs[1] = mk(op_idle(), op_wr(4'd3, 32'h1122_3344, 4'b1100),
                     32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vecs[2] = mk(op_rd(4'd3), op_idle(),
                     32'hAABB_3344, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
        vecs[3] = mk(op_wr(4'd5, 32'h0000_00FF, 4'b1110), op_wr(4'd5, 32'h0000_EE11, 4'b1100),
                     32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        vecs[4] = mk(op_idle(), op_rd(4'd5),
                     32'h0, 1'b0, 1'b0, 32'h0000_EEFF, 1'b1, 1'b1);
        vecs[5] = mk(op_wr(4'd7, 32'h1234_5678, 4'b0000), op_rd(4'd7),
                     32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
        vecs[6] = mk(op_rd(4'd3), op_rd(4'd3),
                     32'hAABB_3344, 1'b1, 1'b1, 32'hAABB_3344, 1'b1, 1'b1);
        vecs[7] = mk(op_idle(), op_idle(),
                     32'hAABB_3344, 1'b0, 1'b1, 32'hAABB_3344, 1'b0, 1'b1);
        vecs[8] = mk(op_wr(4'd7, 32'hDEAD_BEEF, 4'b1111), op_rd(4'd7),
                     32'hAABB_3344, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b1);

        model_reset();
        model_cleared();
        apply(op_idle(), op_idle());

        // Reset state, asserted before any clock edge
        #1 n_reset = 1'b0;
        #1;
        check("rst_do0", do0, 32'h0);
        check("rst_do1", do1, 32'h0);
        check("rst_dv0", 32'(dv0), 32'h0);
        check("rst_dv1", 32'(dv1), 32'h0);
        check("rst_busy", 32'(init_busy), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_hold", 32'(init_busy), 32'h1);

        n_reset = 1'b1;
        run_sweep();
        read_all();

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            drive_cycle(vecs[i].p0, vecs[i].p1);
            settle();
            check($sformatf("vec%0d_dv0", i), 32'(dv0), 32'(vecs[i].dv0));
            check($sformatf("vec%0d_dv1", i), 32'(dv1), 32'(vecs[i].dv1));
            if (vecs[i].chk0) check($sformatf("vec%0d_do0", i), do0, vecs[i].do0);
            if (vecs[i].chk1) check($sformatf("vec%0d_do1", i), do1, vecs[i].do1);
        end

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            op_t a, b;
            a.n_cs = ($urandom_range(3) == 0); a.n_we = 1'($urandom); a.n_be = 4'($urandom);
            a.ad = 4'($urandom);                a.di = $urandom;
            b.n_cs = ($urandom_range(3) == 0); b.n_we = 1'($urandom); b.n_be = 4'($urandom);
            b.ad = ($urandom_range(3) == 0) ? a.ad : 4'($urandom);
            b.di = $urandom;
            drive_cycle(a, b);
        end
        settle();

        // Reset in the middle of a read: outputs clear without a clock edge
        drive_cycle(op_wr(4'd1, 32'hCAFE_F00D, 4'b0000), op_idle());
        drive_cycle(op_rd(4'd1), op_rd(4'd1));
        settle();
        check("pre_rst_do0", do0, 32'hCAFE_F00D);
        apply(op_rd(4'd1), op_rd(4'd1));
        #2 n_reset = 1'b0;
        #1;
        check("midacc_rst_do0", do0, 32'h0);
        check("midacc_rst_do1", do1, 32'h0);
        check("midacc_rst_dv0", 32'(dv0), 32'h0);
        check("midacc_rst_dv1", 32'(dv1), 32'h0);
        check("midacc_rst_busy", 32'(init_busy), 32'h1);
        model_reset();
        apply(op_idle(), op_idle());
        @(posedge clk); #1;
        n_reset = 1'b1;

        // Abort the sweep at address 9, then the full sweep must run again
        repeat (9) @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("midsweep_busy", 32'(init_busy), 32'h1);
        check("midsweep_do0", do0, 32'h0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        run_sweep();
        read_all();

        // Out-of-range addresses on the 12-word instance
        drive_cycle(op_wr(4'd13, 32'h55AA_55AA, 4'b0000), op_rd(4'd13));
        settle();
        check("oor_fwd_do1", s_do1, 32'h0);
        check("oor_fwd_dv1", 32'(s_dv1), 32'h1);
        drive_cycle(op_wr(4'd11, 32'h1357_9BDF, 4'b0000), op_idle());
        drive_cycle(op_rd(4'd13), op_rd(4'd11));
        settle();
        check("oor_rd_do0", s_do0, 32'h0);
        check("oor_rd_dv0", 32'(s_dv0), 32'h1);
        check("last_ad_do1", s_do1, 32'h1357_9BDF);
        check("last_ad_dv1", 32'(s_dv1), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
